// File: rtl/if_id_buffer.sv
// if_id_buffer: IF/ID pipeline buffer for the 5-stage MIPS core.
// It holds up to two fetched words (instruction + PC+4) in a skid FIFO and
// hands them to decode in strict fetch order.
//
// Handshake: a word moves on an edge where valid and ready are both 1
// (push = if_valid & if_ready, pop = id_valid & id_ready). Once valid is
// raised, its payload stays stable until it is consumed. if_ready and
// id_valid are decoded from registered state only, so there is no
// combinational path from id_ready to if_ready.
//
// The occupancy output is the FSM state encoding (EMPTY=0, ONE=1, FULL=2)
// and doubles as the state debug port.
//
// Optional feature macro: IFID_STALLCNT_EN adds the stall_cnt output, a
// 16-bit saturating count of edges where fetch offered a word that was
// refused. It is cleared only by rst_n.
module if_id_buffer #(
    parameter int IW = 32,
    parameter int AW = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          if_valid,
    output logic          if_ready,
    input  logic [IW-1:0] if_instr,
    input  logic [AW-1:0] if_pc4,
    input  logic          flush,
    output logic          id_valid,
    input  logic          id_ready,
    output logic [IW-1:0] id_instr,
    output logic [AW-1:0] id_pc4,
    output logic [1:0]    occupancy
`ifdef IFID_STALLCNT_EN
    ,
    output logic [15:0]   stall_cnt
`endif
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t        state_q, state_d;
    // Entries form a 2-slot ring; head_q selects the slot shown to decode.
    // Using a pointer instead of shifting keeps data flops written on push only.
    logic          head_q, head_d;
    logic [IW-1:0] instr0_q, instr0_d;
    logic [IW-1:0] instr1_q, instr1_d;
    logic [AW-1:0] pc0_q, pc0_d;
    logic [AW-1:0] pc1_q, pc1_d;

    logic push;
    logic pop;
    logic wr_idx;

    // Handshake outputs are pure decodes of the registered state.
    always_comb begin
        if_ready  = (state_q != FULL);
        id_valid  = (state_q != EMPTY);
        occupancy = state_q;
        push      = if_valid & if_ready;
        pop       = id_valid & id_ready;
        // With one word held the free slot is the other one; otherwise the head slot.
        wr_idx    = head_q ^ (state_q == ONE);
        if (!id_valid) begin
            id_instr = '0;
            id_pc4   = '0;
        end else if (head_q) begin
            id_instr = instr1_q;
            id_pc4   = pc1_q;
        end else begin
            id_instr = instr0_q;
            id_pc4   = pc0_q;
        end
    end

    // Next-state, head pointer and entry writes; flush overrides push and pop.
    always_comb begin
        state_d  = state_q;
        head_d   = head_q;
        instr0_d = instr0_q;
        instr1_d = instr1_q;
        pc0_d    = pc0_q;
        pc1_d    = pc1_q;
        if (flush) begin
            state_d = EMPTY;
        end else begin
            if (push) begin
                if (wr_idx) begin
                    instr1_d = if_instr;
                    pc1_d    = if_pc4;
                end else begin
                    instr0_d = if_instr;
                    pc0_d    = if_pc4;
                end
            end
            if (pop) begin
                head_d = ~head_q;
            end
            case (state_q)
                EMPTY: begin
                    if (push) state_d = ONE;
                end
                ONE: begin
                    if (push && !pop)      state_d = FULL;
                    else if (pop && !push) state_d = EMPTY;
                end
                FULL: begin
                    if (pop) state_d = ONE;
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // State, pointer and entry registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            head_q   <= 1'b0;
            instr0_q <= '0;
            instr1_q <= '0;
            pc0_q    <= '0;
            pc1_q    <= '0;
        end else begin
            state_q  <= state_d;
            head_q   <= head_d;
            instr0_q <= instr0_d;
            instr1_q <= instr1_d;
            pc0_q    <= pc0_d;
            pc1_q    <= pc1_d;
        end
    end

`ifdef IFID_STALLCNT_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;

    // Count refused fetch offers, saturating at all-ones.
    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (if_valid && !if_ready && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    // Stall counter register; only reset clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) stall_cnt_q <= '0;
        else        stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_buffer.sv
// Directed bench for if_id_buffer: reset, single pass, back-pressure,
// drain order, simultaneous push/pop, flush and (when built with
// IFID_STALLCNT_EN) the stall counter.
module tb_if_id_buffer;

    logic        clk;
    logic        rst_n;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [31:0] if_pc4;
    logic        flush;
    logic        id_valid;
    logic        id_ready;
    logic [31:0] id_instr;
    logic [31:0] id_pc4;
    logic [1:0]  occupancy;
`ifdef IFID_STALLCNT_EN
    logic [15:0] stall_cnt;
`endif

    int errors = 0;
    int checks = 0;

    if_id_buffer #(.IW(32), .AW(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .if_valid  (if_valid),
        .if_ready  (if_ready),
        .if_instr  (if_instr),
        .if_pc4    (if_pc4),
        .flush     (flush),
        .id_valid  (id_valid),
        .id_ready  (id_ready),
        .id_instr  (id_instr),
        .id_pc4    (id_pc4),
        .occupancy (occupancy)
`ifdef IFID_STALLCNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    // Clock: 10-time-unit period, rising edges at 5, 15, 25, ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one active edge and settle 1 unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc, input logic rdy);
        if_valid = v;
        if_instr = ins;
        if_pc4   = pc;
        id_ready = rdy;
    endtask

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        #1;
        chk("rst_id_valid", {31'b0, id_valid}, 32'd0);
        chk("rst_if_ready", {31'b0, if_ready}, 32'd1);
        chk("rst_occ", {30'b0, occupancy}, 32'd0);
        chk("rst_id_instr", id_instr, 32'h0);
        chk("rst_id_pc4", id_pc4, 32'h0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single pass
        drive(1'b1, 32'h20080005, 32'h4, 1'b1);
        tick();
        chk("sp_id_valid", {31'b0, id_valid}, 32'd1);
        chk("sp_id_instr", id_instr, 32'h20080005);
        chk("sp_id_pc4", id_pc4, 32'h4);
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        tick();
        chk("sp_drained_valid", {31'b0, id_valid}, 32'd0);
        chk("sp_drained_instr", id_instr, 32'h0);
        chk("sp_drained_occ", {30'b0, occupancy}, 32'd0);

        // Back-pressure
        drive(1'b1, 32'h11111111, 32'h100, 1'b0);
        tick();
        chk("bp_occ1", {30'b0, occupancy}, 32'd1);
        drive(1'b1, 32'h22222222, 32'h104, 1'b0);
        tick();
        chk("bp_occ2", {30'b0, occupancy}, 32'd2);
        chk("bp_if_ready", {31'b0, if_ready}, 32'd0);
        chk("bp_hold_instr", id_instr, 32'h11111111);
        drive(1'b1, 32'h99999999, 32'h108, 1'b0);
        tick();
        chk("bp_third_occ", {30'b0, occupancy}, 32'd2);
        chk("bp_third_instr", id_instr, 32'h11111111);
        chk("bp_third_pc4", id_pc4, 32'h100);

        // Drain order
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        tick();
        chk("dr_instr2", id_instr, 32'h22222222);
        chk("dr_pc2", id_pc4, 32'h104);
        chk("dr_occ1", {30'b0, occupancy}, 32'd1);
        chk("dr_if_ready", {31'b0, if_ready}, 32'd1);
        tick();
        chk("dr_empty_valid", {31'b0, id_valid}, 32'd0);
        chk("dr_empty_occ", {30'b0, occupancy}, 32'd0);

        // Simultaneous push and pop in ONE
        drive(1'b1, 32'h44444444, 32'h200, 1'b0);
        tick();
        chk("sim_pre_instr", id_instr, 32'h44444444);
        drive(1'b1, 32'h33333333, 32'h204, 1'b1);
        tick();
        chk("sim_occ", {30'b0, occupancy}, 32'd1);
        chk("sim_instr", id_instr, 32'h33333333);
        chk("sim_pc4", id_pc4, 32'h204);
        drive(1'b0, 32'h0, 32'h0, 1'b1);
        tick();
        chk("sim_drain_occ", {30'b0, occupancy}, 32'd0);

        // Flush from FULL with fetch offering a word
        drive(1'b1, 32'hAAAA0001, 32'h300, 1'b0);
        tick();
        drive(1'b1, 32'hAAAA0002, 32'h304, 1'b0);
        tick();
        chk("fl_full_occ", {30'b0, occupancy}, 32'd2);
        drive(1'b1, 32'hBBBBBBBB, 32'h308, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        chk("fl_occ", {30'b0, occupancy}, 32'd0);
        chk("fl_id_valid", {31'b0, id_valid}, 32'd0);
        chk("fl_if_ready", {31'b0, if_ready}, 32'd1);
        chk("fl_id_instr", id_instr, 32'h0);

        // Flush in ONE with a push and a pop in the same cycle: all discarded
        drive(1'b1, 32'hCCCC0001, 32'h400, 1'b0);
        tick();
        drive(1'b1, 32'hBBBBBBBB, 32'h404, 1'b1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl1_occ", {30'b0, occupancy}, 32'd0);
        chk("fl1_id_instr", id_instr, 32'h0);
        drive(1'b1, 32'hDDDD0001, 32'h500, 1'b0);
        tick();
        chk("fl1_after_instr", id_instr, 32'hDDDD0001);
        chk("fl1_after_pc4", id_pc4, 32'h500);

        // Mid-stream asynchronous reset with FULL
        drive(1'b1, 32'hDDDD0002, 32'h504, 1'b0);
        tick();
        chk("mr_full_occ", {30'b0, occupancy}, 32'd2);
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        chk("mr_id_valid", {31'b0, id_valid}, 32'd0);
        chk("mr_occ", {30'b0, occupancy}, 32'd0);
        chk("mr_if_ready", {31'b0, if_ready}, 32'd1);
        chk("mr_id_instr", id_instr, 32'h0);
        @(posedge clk);
        #1 rst_n = 1'b1;

`ifdef IFID_STALLCNT_EN
        chk("sc_reset", {16'b0, stall_cnt}, 32'd0);
        drive(1'b1, 32'hEEEE0001, 32'h600, 1'b0);
        tick();
        drive(1'b1, 32'hEEEE0002, 32'h604, 1'b0);
        tick();
        chk("sc_no_stall_yet", {16'b0, stall_cnt}, 32'd0);
        drive(1'b1, 32'hEEEE0003, 32'h608, 1'b0);
        repeat (3) tick();
        chk("sc_three", {16'b0, stall_cnt}, 32'd3);
        drive(1'b0, 32'h0, 32'h0, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("sc_flush_keeps", {16'b0, stall_cnt}, 32'd3);
        drive(1'b1, 32'hEEEE0004, 32'h60C, 1'b0);
        repeat (2) tick();
        repeat (70000) tick();
        chk("sc_saturate", {16'b0, stall_cnt}, 32'h0000FFFF);
        drive(1'b0, 32'h0, 32'h0, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
